// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle controller: FSM state encoding,
// ALU operation codes (same encoding the ALU uses), B-operand selects,
// instruction classes and the opcode constants/masks used by the decoder.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_LSL   = 4'b0011;
  localparam logic [3:0] ALU_LSR   = 4'b0100;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BR   = 2'b11;

  typedef enum logic [2:0] {
    C_RTYPE   = 3'd0,
    C_SHIFT   = 3'd1,
    C_LDUR    = 3'd2,
    C_STUR    = 3'd3,
    C_CBZ     = 3'd4,
    C_B       = 3'd5,
    C_MOVZ    = 3'd6,
    C_ILLEGAL = 3'd7
  } iclass_t;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LSR  = 11'b11010011010;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Opcodes whose low bits belong to the immediate field are matched under a mask.
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] OP_B      = 11'b00010100000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;
  localparam logic [10:0] OP_MOVZ   = 11'b11010010100;
  localparam logic [10:0] MASK_MOVZ = 11'b11111111100;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pat,
                                    input logic [10:0] mask);
    return (op & mask) == pat;
  endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// control_decode: purely combinational opcode decoder.
// Ports:
//   opcode   in  [10:0] instruction bits [31:21]
//   alu_ctrl out [3:0]  ALU operation for the instruction's EXEC step
//   iclass   out        instruction class (C_ILLEGAL for unknown opcodes)
//   legal    out        1 when the opcode is recognised
module control_decode
  import multicycle_control_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [3:0]  alu_ctrl,
  output iclass_t     iclass,
  output logic        legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    iclass   = C_ILLEGAL;
    if      (opcode == OP_ADD)  begin alu_ctrl = ALU_ADD; iclass = C_RTYPE; end
    else if (opcode == OP_SUB)  begin alu_ctrl = ALU_SUB; iclass = C_RTYPE; end
    else if (opcode == OP_AND)  begin alu_ctrl = ALU_AND; iclass = C_RTYPE; end
    else if (opcode == OP_ORR)  begin alu_ctrl = ALU_OR;  iclass = C_RTYPE; end
    else if (opcode == OP_LSL)  begin alu_ctrl = ALU_LSL; iclass = C_SHIFT; end
    else if (opcode == OP_LSR)  begin alu_ctrl = ALU_LSR; iclass = C_SHIFT; end
    else if (opcode == OP_LDUR) begin alu_ctrl = ALU_ADD; iclass = C_LDUR;  end
    else if (opcode == OP_STUR) begin alu_ctrl = ALU_ADD; iclass = C_STUR;  end
    else if (op_match(opcode, OP_CBZ, MASK_CBZ))   begin alu_ctrl = ALU_PASSB; iclass = C_CBZ;  end
    else if (op_match(opcode, OP_B, MASK_B))       begin alu_ctrl = ALU_ADD;   iclass = C_B;    end
    else if (op_match(opcode, OP_MOVZ, MASK_MOVZ)) begin alu_ctrl = ALU_PASSB; iclass = C_MOVZ; end
  end

  assign legal = (iclass != C_ILLEGAL);

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: Moore control FSM for a multicycle LEGv8-style datapath.
// Ports:
//   Clk, Reset           clock and synchronous active-high reset
//   Opcode [10:0]        instruction bits [31:21] from IR
//   Zero                 ALU zero flag, only looked at in EXEC of CBZ
//   ALUCtrl [3:0]        ALU operation
//   ALUSrcB [1:0]        B-operand select
//   PCWrite .. Reg2Loc   datapath strobes
//   State [2:0]          current FSM state (debug)
//   Halted               high in HALT
//   BranchFlag           registered CBZ-taken flag, consumed by the next FETCH (debug)
//   InstrCount [CNT_W]   retired-instruction counter (wraps)
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int HALT_ON_ILLEGAL = 1,
  parameter int CNT_W           = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [10:0]      Opcode,
  input  logic             Zero,
  output logic [3:0]       ALUCtrl,
  output logic [1:0]       ALUSrcB,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             Reg2Loc,
  output logic [2:0]       State,
  output logic             Halted,
  output logic             BranchFlag,
  output logic [CNT_W-1:0] InstrCount
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [10:0]       opcode_q;
  logic              branch_flag;
  logic [CNT_W-1:0]  count;

  logic [10:0]       dec_op;
  logic [3:0]        dec_alu;
  iclass_t           dec_class;
  logic              dec_legal;

  // The legality decision is taken in DECODE, the same edge that latches the
  // opcode, so the decoder sees the live opcode only in that state.
  assign dec_op = (state == S_DECODE) ? Opcode : opcode_q;

  control_decode u_decode (
    .opcode   (dec_op),
    .alu_ctrl (dec_alu),
    .iclass   (dec_class),
    .legal    (dec_legal)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_FETCH;
      opcode_q    <= '0;
      branch_flag <= 1'b0;
      count       <= '0;
    end else begin
      unique case (state)
        S_FETCH: begin
          branch_flag <= 1'b0;
          state       <= S_DECODE;
        end
        S_DECODE: begin
          opcode_q <= Opcode;
          if (dec_legal)                 state <= S_EXEC;
          else if (HALT_ON_ILLEGAL != 0) state <= S_HALT;
          else                           state <= S_FETCH;
        end
        S_EXEC: begin
          case (dec_class)
            C_LDUR, C_STUR: state <= S_MEM;
            C_CBZ: begin
              branch_flag <= Zero;
              count       <= count + CNT_ONE;
              state       <= S_FETCH;
            end
            C_B: begin
              count <= count + CNT_ONE;
              state <= S_FETCH;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (dec_class == C_LDUR) begin
            state <= S_WB;
          end else begin
            count <= count + CNT_ONE;
            state <= S_FETCH;
          end
        end
        S_WB: begin
          count <= count + CNT_ONE;
          state <= S_FETCH;
        end
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    ALUCtrl  = ALU_ADD;
    ALUSrcB  = SRCB_REG;
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    Reg2Loc  = 1'b0;
    Halted   = 1'b0;
    case (state)
      S_FETCH: begin
        // With branch_flag set the PC write loads the CBZ target chosen by
        // the datapath instead of PC+4; the strobe itself is the same.
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = SRCB_FOUR;
        ALUCtrl = ALU_ADD;
        PCWrite = 1'b1;
      end
      S_EXEC: begin
        ALUCtrl = dec_alu;
        case (dec_class)
          C_RTYPE: ALUSrcB = SRCB_REG;
          C_SHIFT, C_LDUR, C_STUR, C_MOVZ: ALUSrcB = SRCB_IMM;
          C_CBZ: begin
            ALUSrcB = SRCB_REG;
            Reg2Loc = 1'b1;
          end
          C_B: begin
            ALUSrcB = SRCB_BR;
            PCWrite = 1'b1;
          end
          default: ALUSrcB = SRCB_REG;
        endcase
      end
      S_MEM: begin
        if (dec_class == C_LDUR) begin
          MemRead = 1'b1;
        end else begin
          MemWrite = 1'b1;
          Reg2Loc  = 1'b1;
        end
      end
      S_WB: begin
        RegWrite = 1'b1;
        MemtoReg = (dec_class == C_LDUR);
      end
      S_HALT:  Halted = 1'b1;
      default: ;
    endcase
    // No architectural write may happen in a cycle that is being reset.
    if (Reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
      MemWrite = 1'b0;
    end
  end

  assign State      = state;
  assign BranchFlag = branch_flag;
  assign InstrCount = count;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a table of single instructions with
// hand-computed cycle counts and EXEC outputs, plus sequences for reset,
// illegal opcodes, reset during MEM and counter wrap.
module tb_multicycle_control;
  import multicycle_control_pkg::*;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #20 Clk = ~Clk;

  logic        rst = 1'b1, zero = 1'b0;
  logic [10:0] op = '0;
  logic [3:0]  alu_ctrl;
  logic [1:0]  srcb;
  logic        pc_write, ir_write, reg_write, mem_read, mem_write, memto_reg, reg2loc;
  logic [2:0]  state;
  logic        halted, branch_flag;
  logic [31:0] count;

  multicycle_control dut (
    .Clk(Clk), .Reset(rst), .Opcode(op), .Zero(zero),
    .ALUCtrl(alu_ctrl), .ALUSrcB(srcb), .PCWrite(pc_write), .IRWrite(ir_write),
    .RegWrite(reg_write), .MemRead(mem_read), .MemWrite(mem_write),
    .MemtoReg(memto_reg), .Reg2Loc(reg2loc), .State(state), .Halted(halted),
    .BranchFlag(branch_flag), .InstrCount(count)
  );

  // Narrow-counter instance that treats illegal opcodes as NOPs.
  logic        rst4 = 1'b1, zero4 = 1'b0;
  logic [10:0] op4 = '0;
  logic [3:0]  alu_ctrl4;
  logic [1:0]  srcb4;
  logic        pc_write4, ir_write4, reg_write4, mem_read4, mem_write4, memto_reg4, reg2loc4;
  logic [2:0]  state4;
  logic        halted4, branch_flag4;
  logic [3:0]  count4;

  multicycle_control #(.HALT_ON_ILLEGAL(0), .CNT_W(4)) dut4 (
    .Clk(Clk), .Reset(rst4), .Opcode(op4), .Zero(zero4),
    .ALUCtrl(alu_ctrl4), .ALUSrcB(srcb4), .PCWrite(pc_write4), .IRWrite(ir_write4),
    .RegWrite(reg_write4), .MemRead(mem_read4), .MemWrite(mem_write4),
    .MemtoReg(memto_reg4), .Reg2Loc(reg2loc4), .State(state4), .Halted(halted4),
    .BranchFlag(branch_flag4), .InstrCount(count4)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_pcwrite", pc_write, 0);
    check("rst_irwrite", ir_write, 0);
    check("rst_regwrite", reg_write, 0);
    check("rst_memwrite", mem_write, 0);
    tick();
    rst = 1'b0;
  endtask

  task automatic run_instr(input logic [10:0] o, input logic z,
                           output int cycles, output logic [3:0] alu_e,
                           output logic [1:0] srcb_e, output logic r2l_e,
                           output logic pcw_e, output int rw, output int mw,
                           output logic mtr);
    op = o; zero = z;
    cycles = 0; rw = 0; mw = 0; mtr = 1'b0;
    alu_e = 4'hf; srcb_e = 2'bxx; r2l_e = 1'bx; pcw_e = 1'bx;
    do begin
      if (state == S_EXEC) begin
        alu_e = alu_ctrl; srcb_e = srcb; r2l_e = reg2loc; pcw_e = pc_write;
      end
      if (reg_write) rw++;
      if (mem_write) mw++;
      if (memto_reg) mtr = 1'b1;
      tick();
      cycles++;
    end while (state != S_FETCH && state != S_HALT && cycles < 12);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [10:0] op;
    logic        zero;
    int          cycles;
    logic [3:0]  alu;
    logic [1:0]  srcb;
    logic        r2l;
    logic        pcw;
    int          rw;
    int          mw;
    logic        mtr;
    logic        bf;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int cyc, rw, mw;
    logic [3:0] a;
    logic [1:0] sb;
    logic r2l, pcw, mtr;
    int exp_count;
    logic [2:0] exp_s;

    //               op              z  cyc alu     srcb  r2l pcw rw mw mtr bf
    vecs[0]  = '{11'b10001011000, 1'b0, 4, 4'b0010, 2'b00, 0, 0, 1, 0, 0, 0}; // ADD
    vecs[1]  = '{11'b11001011000, 1'b0, 4, 4'b0110, 2'b00, 0, 0, 1, 0, 0, 0}; // SUB
    vecs[2]  = '{11'b10001010000, 1'b0, 4, 4'b0000, 2'b00, 0, 0, 1, 0, 0, 0}; // AND
    vecs[3]  = '{11'b10101010000, 1'b0, 4, 4'b0001, 2'b00, 0, 0, 1, 0, 0, 0}; // ORR
    vecs[4]  = '{11'b11010011011, 1'b0, 4, 4'b0011, 2'b10, 0, 0, 1, 0, 0, 0}; // LSL
    vecs[5]  = '{11'b11010011010, 1'b0, 4, 4'b0100, 2'b10, 0, 0, 1, 0, 0, 0}; // LSR
    vecs[6]  = '{11'b11111000010, 1'b0, 5, 4'b0010, 2'b10, 0, 0, 1, 0, 1, 0}; // LDUR
    vecs[7]  = '{11'b11111000000, 1'b0, 4, 4'b0010, 2'b10, 0, 0, 0, 1, 0, 0}; // STUR
    vecs[8]  = '{11'b11010010110, 1'b0, 4, 4'b0111, 2'b10, 0, 0, 1, 0, 0, 0}; // MOVZ
    vecs[9]  = '{11'b10110100101, 1'b1, 3, 4'b0111, 2'b00, 1, 0, 0, 0, 0, 1}; // CBZ taken
    vecs[10] = '{11'b10110100011, 1'b0, 3, 4'b0111, 2'b00, 1, 0, 0, 0, 0, 0}; // CBZ not taken
    vecs[11] = '{11'b00010111010, 1'b0, 3, 4'b0010, 2'b11, 0, 1, 0, 0, 0, 0}; // B

    // ---- reset state ----
    #5;
    apply_reset();
    check("reset_state", state, S_FETCH);
    check("reset_halted", halted, 0);
    check("reset_count", count, 0);
    check("reset_branch_flag", branch_flag, 0);

    // ---- ADD: explicit state walk, RegWrite only in WB ----
    exp_q.push_back(S_FETCH); exp_q.push_back(S_DECODE);
    exp_q.push_back(S_EXEC);  exp_q.push_back(S_WB);
    exp_q.push_back(S_FETCH);
    op = OP_ADD;
    for (int i = 0; i < 5; i++) begin
      exp_s = exp_q.pop_front();
      check($sformatf("add_state_c%0d", i), state, exp_s);
      check($sformatf("add_regwrite_c%0d", i), reg_write, (exp_s == S_WB) ? 1 : 0);
      if (exp_s == S_EXEC) check("add_exec_alu", alu_ctrl, 4'b0010);
      if (i < 4) tick();
    end
    check("add_count", count, 1);
    exp_count = 1;

    // ---- table-driven instructions ----
    for (int i = 0; i < 12; i++) begin
      run_instr(vecs[i].op, vecs[i].zero, cyc, a, sb, r2l, pcw, rw, mw, mtr);
      exp_count++;
      check($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
      check($sformatf("v%0d_alu", i), a, vecs[i].alu);
      check($sformatf("v%0d_srcb", i), sb, vecs[i].srcb);
      check($sformatf("v%0d_reg2loc", i), r2l, vecs[i].r2l);
      check($sformatf("v%0d_exec_pcwrite", i), pcw, vecs[i].pcw);
      check($sformatf("v%0d_regwrite_cycles", i), rw, vecs[i].rw);
      check($sformatf("v%0d_memwrite_cycles", i), mw, vecs[i].mw);
      check($sformatf("v%0d_memtoreg", i), mtr, vecs[i].mtr);
      check($sformatf("v%0d_branch_flag", i), branch_flag, vecs[i].bf);
      check($sformatf("v%0d_fetch_pcwrite", i), pc_write, 1);
      check($sformatf("v%0d_count", i), count, exp_count);
    end

    // ---- illegal opcode halts and holds ----
    op = 11'b00000000000;
    tick(); tick();
    check("illegal_state", state, S_HALT);
    check("illegal_halted", halted, 1);
    check("illegal_count", count, exp_count);
    tick(); tick(); tick();
    check("halt_sticky_state", state, S_HALT);
    check("halt_pcwrite", pc_write, 0);
    check("halt_memread", mem_read, 0);
    check("halt_irwrite", ir_write, 0);
    apply_reset();
    check("halt_reset_state", state, S_FETCH);
    check("halt_reset_halted", halted, 0);
    check("halt_reset_count", count, 0);

    // ---- reset during MEM of STUR ----
    op = OP_STUR;
    tick(); tick(); tick();
    check("stur_mem_state", state, S_MEM);
    check("stur_mem_memwrite", mem_write, 1);
    rst = 1'b1;
    #1;
    check("stur_rst_memwrite_now", mem_write, 0);
    tick();
    check("stur_rst_state", state, S_FETCH);
    check("stur_rst_memwrite_next", mem_write, 0);
    check("stur_rst_count", count, 0);
    check("stur_rst_pcwrite", pc_write, 0);
    rst = 1'b0;

    // ---- narrow counter: illegal as NOP, then 17 B instructions ----
    rst4 = 1'b1;
    tick();
    rst4 = 1'b0;
    op4 = 11'b00000000000;
    tick(); tick();
    check("nop_state", state4, S_FETCH);
    check("nop_halted", halted4, 0);
    check("nop_count", count4, 0);
    op4 = OP_B;
    for (int i = 0; i < 17; i++) begin
      tick(); tick(); tick();
      if (i == 15) check("wrap_to_zero", count4, 0);
    end
    check("wrap_state", state4, S_FETCH);
    check("wrap_count", count4, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter HALT_ON_ILLEGAL, default 1, meaning: 1 = enter HALT on an unknown opcode; 0 = treat it as a NOP and return to FETCH.
REQ-002 Parameter CNT_W, default 32, meaning: width of the retired-instruction counter.
REQ-003 Clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 Opcode  input  11  instruction bits [31:21], valid while IR holds the fetched instruction.
REQ-006 Zero  input  1  ALU zero flag, sampled only in EXEC.
REQ-007 ALUCtrl  output  4  ALU operation: AND 0000, OR 0001, ADD 0010, LSL 0011, LSR 0100, SUB 0110, PassB 0111.
REQ-008 ALUSrcB  output  2  B-operand select: 00 register, 01 constant 4, 10 sign-extended immediate, 11 branch offset shifted left 2.
REQ-009 PCWrite, IRWrite, RegWrite, MemRead, MemWrite, MemtoReg, Reg2Loc  outputs  1 each  datapath strobes.
REQ-010 State  output  3  current FSM state, for debug.
REQ-011 Halted  output  1  high while in HALT.
REQ-012 InstrCount  output  CNT_W  number of retired instructions.

Function
REQ-013 States are FETCH, DECODE, EXEC, MEM, WB and HALT.
REQ-014 Opcode is latched into an internal register in DECODE; all later decode uses the latched value only.
REQ-015 Outputs are combinational from the state register and the latched opcode (Moore); no output depends on Zero combinationally.
REQ-016 FETCH: MemRead=1, IRWrite=1, ALUSrcB=01, ALUCtrl=ADD, PCWrite=1; next state DECODE.
REQ-017 DECODE: all strobes 0; next state EXEC if the opcode is legal, else HALT (HALT_ON_ILLEGAL=1) or FETCH (HALT_ON_ILLEGAL=0).
REQ-018 R-type decode: ADD 10001011000 -> ADD; SUB 11001011000 -> SUB; AND 10001010000 -> AND; ORR 10101010000 -> OR; LSL 11010011011 -> LSL; LSR 11010011010 -> LSR.
REQ-019 Other decode: LDUR 11111000010; STUR 11111000000; CBZ 10110100xxx; B 000101xxxxx; MOVZ 110100101xx -> PassB.
REQ-020 EXEC, R-type: ALUSrcB=00, Reg2Loc=0; shifts use ALUSrcB=10; next state WB.
REQ-021 EXEC, LDUR/STUR: ALUCtrl=ADD, ALUSrcB=10; next state MEM.
REQ-022 EXEC, MOVZ: ALUCtrl=PassB, ALUSrcB=10; next state WB.
REQ-023 EXEC, CBZ: ALUCtrl=PassB, ALUSrcB=00, Reg2Loc=1; Zero is sampled at the end of EXEC; next state FETCH.
REQ-024 EXEC, B: PCWrite=1, ALUSrcB=11; next state FETCH.
REQ-025 CBZ taken: a registered flag set by Zero drives PCWrite=1 in the following FETCH instead of the PC+4 write; branch-target sequencing belongs to the datapath.
REQ-026 MEM, LDUR: MemRead=1; next state WB.
REQ-027 MEM, STUR: MemWrite=1, Reg2Loc=1; next state FETCH.
REQ-028 WB: RegWrite=1; MemtoReg=1 for LDUR, else 0; next state FETCH.
REQ-029 Cycles per instruction: R-type and MOVZ 4; LDUR 5; STUR 4; CBZ and B 3.
REQ-030 InstrCount increments by 1 on the final cycle of each legal instruction.
REQ-031 InstrCount wraps from all-ones to 0.
REQ-032 An illegal opcode does not increment InstrCount.
REQ-033 HALT is absorbing: all strobes 0, Halted=1; only Reset leaves it.
REQ-034 The clock period shall exceed the ALU propagation delay of 20 time units so that Zero has settled before the EXEC edge.

Reset
REQ-035 Reset has priority over every transition and takes effect on the next rising edge, including mid-instruction.
REQ-036 After reset: state FETCH; latched opcode 0; branch flag 0; InstrCount 0; Halted 0.
REQ-037 In the reset cycle itself, all write strobes (PCWrite, IRWrite, RegWrite, MemWrite) are forced to 0.

Structure
REQ-038 A shared package holds the state encodings, the ALUCtrl encodings (identical to the ALU's) and the opcode constants and masks.
REQ-039 The opcode-to-ALUCtrl/legality decode is a single combinational sub-module, control_decode.

Verification
REQ-040 Reset, then ADD opcode 10001011000 -> states FETCH, DECODE, EXEC, WB; ALUCtrl=0010 in EXEC; RegWrite=1 only in WB; InstrCount=1.
REQ-041 LDUR then STUR -> 5 then 4 cycles; MemtoReg=1 in LDUR WB; MemWrite=1 for exactly 1 cycle; InstrCount=2.
REQ-042 CBZ with Zero=1, then CBZ with Zero=0 -> branch flag set only for the first; 3 cycles each.
REQ-043 Opcode 00000000000 with HALT_ON_ILLEGAL=1 -> HALT, Halted=1, InstrCount unchanged; Reset then returns the FSM to FETCH.
REQ-044 Reset asserted during MEM of STUR -> MemWrite=0 on the following cycle; state FETCH; InstrCount=0.
REQ-045 CNT_W=4, 17 back-to-back B instructions -> InstrCount wraps to 1.
